// File: rtl/conv_loop_scheduler.sv
// Loop sequencer for a zero-padded "same" convolution: walks y, x, co, ky, kx, ci,
// paces the MAC through every tap with valid/ready handshakes and flags padded taps.
module conv_loop_scheduler #(
  parameter int FEATURE_MAP_WIDTH  = 128,
  parameter int FEATURE_MAP_HEIGHT = 128,
  parameter int INPUT_NB_CHANNELS  = 2,
  parameter int OUTPUT_NB_CHANNELS = 16,
  parameter int KERNEL_SIZE        = 3
) (
  input  logic clk,
  input  logic arst_n_in,
  input  logic start,
  output logic running,
  output logic fsm_done,
  input  logic a_valid,
  output logic a_ready,
  input  logic b_valid,
  output logic b_ready,
  output logic a_zero_flag,
  output logic signed [$clog2(FEATURE_MAP_WIDTH):0]  tap_x,
  output logic signed [$clog2(FEATURE_MAP_HEIGHT):0] tap_y,
  output logic [((INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1)-1:0] tap_ci,
  output logic mac_valid,
  output logic mac_first,
  output logic mac_last,
  output logic output_valid,
  output logic [((FEATURE_MAP_WIDTH > 1) ? $clog2(FEATURE_MAP_WIDTH) : 1)-1:0]   output_x,
  output logic [((FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1)-1:0] output_y,
  output logic [((OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1)-1:0] output_ch
);

  localparam int XW   = (FEATURE_MAP_WIDTH > 1)  ? $clog2(FEATURE_MAP_WIDTH)  : 1;
  localparam int YW   = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
  localparam int CIW  = (INPUT_NB_CHANNELS > 1)  ? $clog2(INPUT_NB_CHANNELS)  : 1;
  localparam int COW  = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
  localparam int KW   = (KERNEL_SIZE > 1)        ? $clog2(KERNEL_SIZE)        : 1;
  localparam int TXW  = $clog2(FEATURE_MAP_WIDTH) + 1;
  localparam int TYW  = $clog2(FEATURE_MAP_HEIGHT) + 1;
  localparam int HALF = (KERNEL_SIZE - 1) / 2;

  localparam logic [XW-1:0]  X_MAX  = XW'(FEATURE_MAP_WIDTH - 1);
  localparam logic [YW-1:0]  Y_MAX  = YW'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [CIW-1:0] CI_MAX = CIW'(INPUT_NB_CHANNELS - 1);
  localparam logic [COW-1:0] CO_MAX = COW'(OUTPUT_NB_CHANNELS - 1);
  localparam logic [KW-1:0]  K_MAX  = KW'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;

  state_t          state_reg;
  logic [YW-1:0]   y_reg;
  logic [XW-1:0]   x_reg;
  logic [COW-1:0]  co_reg;
  logic [KW-1:0]   ky_reg;
  logic [KW-1:0]   kx_reg;
  logic [CIW-1:0]  ci_reg;
  logic            running_reg;
  logic            done_reg;
  logic            out_valid_reg;
  logic [XW-1:0]   output_x_reg;
  logic [YW-1:0]   output_y_reg;
  logic [COW-1:0]  output_ch_reg;

  int   tap_x_full;
  int   tap_y_full;
  logic in_mac;
  logic pad;
  logic fire;
  logic tap_first;
  logic tap_last;
  logic last_output;

  // Tap coordinates are evaluated at full integer width so padding detection never
  // suffers from the narrow output port wrapping around.
  always_comb begin
    tap_x_full  = int'(x_reg) + int'(kx_reg) - HALF;
    tap_y_full  = int'(y_reg) + int'(ky_reg) - HALF;
    in_mac      = (state_reg == S_MAC);
    pad         = in_mac && ((tap_x_full < 0) || (tap_x_full >= FEATURE_MAP_WIDTH) ||
                             (tap_y_full < 0) || (tap_y_full >= FEATURE_MAP_HEIGHT));
    fire        = in_mac && (a_valid || pad) && b_valid;
    tap_first   = (ky_reg == '0) && (kx_reg == '0) && (ci_reg == '0);
    tap_last    = (ky_reg == K_MAX) && (kx_reg == K_MAX) && (ci_reg == CI_MAX);
    last_output = (y_reg == Y_MAX) && (x_reg == X_MAX) && (co_reg == CO_MAX);
  end

  assign a_zero_flag  = pad;
  assign a_ready      = in_mac && !pad && b_valid;
  assign b_ready      = in_mac && (a_valid || pad);
  assign mac_valid    = fire;
  assign mac_first    = fire && tap_first;
  assign mac_last     = fire && tap_last;
  assign tap_x        = in_mac ? tap_x_full[TXW-1:0] : '0;
  assign tap_y        = in_mac ? tap_y_full[TYW-1:0] : '0;
  assign tap_ci       = ci_reg;
  assign running      = running_reg;
  assign fsm_done     = done_reg;
  assign output_valid = out_valid_reg;
  assign output_x     = output_x_reg;
  assign output_y     = output_y_reg;
  assign output_ch    = output_ch_reg;

  always_ff @(posedge clk) begin
    if (!arst_n_in) begin
      state_reg     <= S_IDLE;
      y_reg         <= '0;
      x_reg         <= '0;
      co_reg        <= '0;
      ky_reg        <= '0;
      kx_reg        <= '0;
      ci_reg        <= '0;
      running_reg   <= 1'b0;
      done_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      output_x_reg  <= '0;
      output_y_reg  <= '0;
      output_ch_reg <= '0;
    end else begin
      done_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg   <= S_MAC;
            running_reg <= 1'b1;
          end
        end
        S_MAC: begin
          if (fire) begin
            // Innermost-first carry chain; all three wrap to 0 on the last tap.
            if (ci_reg == CI_MAX) begin
              ci_reg <= '0;
              if (kx_reg == K_MAX) begin
                kx_reg <= '0;
                ky_reg <= (ky_reg == K_MAX) ? '0 : ky_reg + 1'b1;
              end else begin
                kx_reg <= kx_reg + 1'b1;
              end
            end else begin
              ci_reg <= ci_reg + 1'b1;
            end
            if (tap_last) begin
              state_reg     <= S_OUT;
              out_valid_reg <= 1'b1;
              output_x_reg  <= x_reg;
              output_y_reg  <= y_reg;
              output_ch_reg <= co_reg;
            end
          end
        end
        S_OUT: begin
          if (co_reg == CO_MAX) begin
            co_reg <= '0;
            if (x_reg == X_MAX) begin
              x_reg <= '0;
              y_reg <= (y_reg == Y_MAX) ? '0 : y_reg + 1'b1;
            end else begin
              x_reg <= x_reg + 1'b1;
            end
          end else begin
            co_reg <= co_reg + 1'b1;
          end
          if (last_output) begin
            state_reg <= S_DONE;
            done_reg  <= 1'b1;
          end else begin
            state_reg <= S_MAC;
          end
        end
        S_DONE: begin
          state_reg   <= S_IDLE;
          running_reg <= 1'b0;
        end
        default: begin
          state_reg   <= S_IDLE;
          running_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_loop_scheduler.sv
// Self-checking bench: a 4x4x2->2 K=3 instance driven by a table of layer runs plus
// hand sequences (corner taps, mid-layer reset, restart), and a 2x2 K=1 instance.
module tb_conv_loop_scheduler;

  localparam int W = 4, H = 4, CI = 2, CO = 2, K = 3, HALF = 1;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, a_valid, b_valid;
  logic running, fsm_done, a_ready, b_ready, a_zero_flag;
  logic mac_valid, mac_first, mac_last, output_valid;
  logic signed [2:0] tap_x, tap_y;
  logic [0:0] tap_ci;
  logic [1:0] output_x, output_y;
  logic [0:0] output_ch;

  logic s_start, s_a_valid, s_b_valid;
  logic s_running, s_fsm_done, s_a_ready, s_b_ready, s_a_zero_flag;
  logic s_mac_valid, s_mac_first, s_mac_last, s_output_valid;
  logic signed [1:0] s_tap_x, s_tap_y;
  logic [0:0] s_tap_ci, s_output_x, s_output_y, s_output_ch;

  conv_loop_scheduler #(
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .INPUT_NB_CHANNELS(CI),
    .OUTPUT_NB_CHANNELS(CO), .KERNEL_SIZE(K)
  ) dut (
    .clk(clk), .arst_n_in(rst_n), .start(start), .running(running), .fsm_done(fsm_done),
    .a_valid(a_valid), .a_ready(a_ready), .b_valid(b_valid), .b_ready(b_ready),
    .a_zero_flag(a_zero_flag), .tap_x(tap_x), .tap_y(tap_y), .tap_ci(tap_ci),
    .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last),
    .output_valid(output_valid), .output_x(output_x), .output_y(output_y), .output_ch(output_ch)
  );

  conv_loop_scheduler #(
    .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .INPUT_NB_CHANNELS(1),
    .OUTPUT_NB_CHANNELS(1), .KERNEL_SIZE(1)
  ) dut_small (
    .clk(clk), .arst_n_in(rst_n), .start(s_start), .running(s_running), .fsm_done(s_fsm_done),
    .a_valid(s_a_valid), .a_ready(s_a_ready), .b_valid(s_b_valid), .b_ready(s_b_ready),
    .a_zero_flag(s_a_zero_flag), .tap_x(s_tap_x), .tap_y(s_tap_y), .tap_ci(s_tap_ci),
    .mac_valid(s_mac_valid), .mac_first(s_mac_first), .mac_last(s_mac_last),
    .output_valid(s_output_valid), .output_x(s_output_x), .output_y(s_output_y),
    .output_ch(s_output_ch)
  );

  typedef struct {
    string name;
    bit    rand_valid;
    bit    restart;
    int    exp_outs;
    int    exp_fires;
    int    exp_first;
    int    exp_last;
    int    exp_axfer;
    int    exp_corner_pad;
    int    exp_corner_ar;
    int    exp_cycles;
  } vec_t;

  int checks = 0, errors = 0, cyc = 0;
  bit mon_en = 0, zero_req = 0, rand_mode = 0;

  // reference loop model for the main instance
  int m_y = 0, m_x = 0, m_co = 0, m_ky = 0, m_kx = 0, m_ci = 0;
  bit prev_running = 0;
  int outs = 0, fires = 0, firsts = 0, lasts = 0, a_xfer = 0, done_cnt = 0;
  int corner_taps = 0, corner_pad = 0, corner_ar = 0;
  int first_mac_cyc = 0, done_cyc = 0;

  int s_mx = 0, s_my = 0;
  bit s_prev_running = 0;
  int s_outs = 0, s_fires = 0, s_bad = 0, s_zero = 0, s_done_cnt = 0;
  int s_first_cyc = 0, s_done_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_main();
    int tx, ty;
    bit pad, efire, efirst, elast, mac;
    logic signed [2:0] tx3, ty3;
    if (running && !prev_running) first_mac_cyc = cyc;
    if (!running) begin
      m_y = 0; m_x = 0; m_co = 0; m_ky = 0; m_kx = 0; m_ci = 0;
      chk("idle_quiet", int'(a_ready | b_ready | mac_valid | output_valid | fsm_done), 0);
    end
    mac = running && !output_valid && !fsm_done;
    if (mac) begin
      tx = m_x + m_kx - HALF;
      ty = m_y + m_ky - HALF;
      pad = (tx < 0) || (tx >= W) || (ty < 0) || (ty >= H);
      efire = (a_valid || pad) && b_valid;
      efirst = efire && m_ky == 0 && m_kx == 0 && m_ci == 0;
      elast = efire && m_ky == K - 1 && m_kx == K - 1 && m_ci == CI - 1;
      tx3 = 3'(tx);
      ty3 = 3'(ty);
      chk("tap_x", int'(tap_x), int'(tx3));
      chk("tap_y", int'(tap_y), int'(ty3));
      chk("tap_ci", int'(tap_ci), m_ci);
      chk("a_zero_flag", int'(a_zero_flag), int'(pad));
      chk("mac_valid", int'(mac_valid), int'(efire));
      chk("a_ready", int'(a_ready), int'(!pad && b_valid));
      chk("b_ready", int'(b_ready), int'(a_valid || pad));
      chk("mac_first", int'(mac_first), int'(efirst));
      chk("mac_last", int'(mac_last), int'(elast));
      if (mac_valid) begin
        fires++;
        firsts += int'(mac_first);
        lasts += int'(mac_last);
        if (a_valid && a_ready) a_xfer++;
        if (m_y == 0 && m_x == 0) begin
          corner_taps++;
          corner_pad += int'(a_zero_flag);
          corner_ar += int'(a_ready);
        end
      end
      if (efire) begin
        if (m_ci == CI - 1) begin
          m_ci = 0;
          if (m_kx == K - 1) begin
            m_kx = 0;
            if (m_ky == K - 1) m_ky = 0; else m_ky++;
          end else m_kx++;
        end else m_ci++;
      end
    end else if (running && output_valid) begin
      chk("output_x", int'(output_x), m_x);
      chk("output_y", int'(output_y), m_y);
      chk("output_ch", int'(output_ch), m_co);
      chk("out_quiet", int'(a_ready | b_ready | mac_valid), 0);
      outs++;
      if (m_co == CO - 1) begin
        m_co = 0;
        if (m_x == W - 1) begin
          m_x = 0;
          if (m_y == H - 1) m_y = 0; else m_y++;
        end else m_x++;
      end else m_co++;
    end
    if (fsm_done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_quiet", int'(a_ready | b_ready | mac_valid | output_valid), 0);
    end
    prev_running = running;
  endtask

  task automatic mon_small();
    if (s_running && !s_prev_running) s_first_cyc = cyc;
    if (!s_running) begin s_mx = 0; s_my = 0; end
    chk("s_a_ready", int'(s_a_ready), int'(s_mac_valid));
    chk("s_b_ready", int'(s_b_ready), int'(s_mac_valid));
    if (s_mac_valid) begin
      s_fires++;
      if (!(s_mac_first && s_mac_last)) s_bad++;
      chk("s_tap_x", int'(s_tap_x), s_mx);
      chk("s_tap_y", int'(s_tap_y), s_my);
      chk("s_tap_ci", int'(s_tap_ci), 0);
    end
    if (s_a_zero_flag) s_zero++;
    if (s_output_valid) begin
      chk("s_output_x", int'(s_output_x), s_mx);
      chk("s_output_y", int'(s_output_y), s_my);
      chk("s_output_ch", int'(s_output_ch), 0);
      s_outs++;
      if (s_mx == 1) begin s_mx = 0; s_my++; end else s_mx++;
    end
    if (s_fsm_done) begin s_done_cnt++; s_done_cyc = cyc; end
    s_prev_running = s_running;
  endtask

  task automatic zero_checks();
    chk("rst_running", int'(running), 0);
    chk("rst_fsm_done", int'(fsm_done), 0);
    chk("rst_ready", int'({a_ready, b_ready}), 0);
    chk("rst_strobes", int'({mac_valid, mac_first, mac_last, a_zero_flag, output_valid}), 0);
    chk("rst_tap", int'({tap_x, tap_y, tap_ci}), 0);
    chk("rst_out_coord", int'({output_x, output_y, output_ch}), 0);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (zero_req) zero_checks();
    if (mon_en) begin
      mon_main();
      mon_small();
    end
    @(posedge clk);
    #1;
    if (rand_mode) begin
      a_valid = 1'($urandom_range(0, 1));
      b_valid = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic vec_t mk(input string name, input bit rv, input bit rs, input int cycles);
    vec_t v;
    v.name = name; v.rand_valid = rv; v.restart = rs;
    v.exp_outs = 32; v.exp_fires = 576; v.exp_first = 32; v.exp_last = 32;
    v.exp_axfer = 400; v.exp_corner_pad = 20; v.exp_corner_ar = 16;
    v.exp_cycles = cycles;
    return v;
  endfunction

  task automatic run_and_check(input vec_t v);
    int o0, f0, fi0, l0, x0, ct0, cp0, ca0, d0, n;
    o0 = outs; f0 = fires; fi0 = firsts; l0 = lasts; x0 = a_xfer;
    ct0 = corner_taps; cp0 = corner_pad; ca0 = corner_ar; d0 = done_cnt;
    rand_mode = v.rand_valid;
    if (!v.rand_valid) begin a_valid = 1'b1; b_valid = 1'b1; end
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 20000) begin
      if (v.restart && (n == 50 || n == 300)) start = 1'b1;
      tick();
      start = 1'b0;
      n++;
    end
    chk({v.name, "_done_pulses"}, done_cnt - d0, 1);
    chk({v.name, "_running_after"}, int'(running), 0);
    tick();
    tick();
    rand_mode = 0;
    chk({v.name, "_no_extra_done"}, done_cnt - d0, 1);
    chk({v.name, "_outputs"}, outs - o0, v.exp_outs);
    chk({v.name, "_fires"}, fires - f0, v.exp_fires);
    chk({v.name, "_mac_first"}, firsts - fi0, v.exp_first);
    chk({v.name, "_mac_last"}, lasts - l0, v.exp_last);
    chk({v.name, "_a_xfers"}, a_xfer - x0, v.exp_axfer);
    chk({v.name, "_corner_taps"}, corner_taps - ct0, 36);
    chk({v.name, "_corner_pad"}, corner_pad - cp0, v.exp_corner_pad);
    chk({v.name, "_corner_a_ready"}, corner_ar - ca0, v.exp_corner_ar);
    if (v.exp_cycles >= 0)
      chk({v.name, "_layer_cycles"}, done_cyc - first_mac_cyc + 1, v.exp_cycles);
    $display("run %s: outputs %0d fires %0d cycles %0d", v.name, outs - o0, fires - f0,
             done_cyc - first_mac_cyc + 1);
  endtask

  initial begin
    vec_t vecs[3];
    vec_t v;
    int f0, d0, o0, n;
    vecs[0] = mk("full_rate", 1'b0, 1'b0, 609);
    vecs[1] = mk("random_valid", 1'b1, 1'b0, -1);
    vecs[2] = mk("restart_ignored", 1'b0, 1'b1, 609);

    rst_n = 1'b0; start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    s_start = 1'b0; s_a_valid = 1'b1; s_b_valid = 1'b1;
    tick();
    tick();
    zero_req = 1;
    tick();
    zero_req = 0;
    rst_n = 1'b1;
    mon_en = 1;
    tick();

    for (int i = 0; i < 3; i++) run_and_check(vecs[i]);

    // mid-layer reset after 100 fires
    a_valid = 1'b1; b_valid = 1'b1;
    f0 = fires; d0 = done_cnt; o0 = outs;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (fires - f0 < 100 && n < 1000) begin tick(); n++; end
    chk("abort_fires_reached", fires - f0, 100);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    zero_req = 1;
    tick();
    zero_req = 0;
    tick();
    tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_outputs", outs - o0, 5);
    $display("run abort: outputs %0d fires %0d", outs - o0, fires - f0);
    v = vecs[0];
    v.name = "after_abort";
    run_and_check(v);

    // K=1 instance
    d0 = s_done_cnt; o0 = s_outs; f0 = s_fires;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    n = 0;
    while (s_done_cnt == d0 && n < 200) begin tick(); n++; end
    tick();
    chk("small_done_pulses", s_done_cnt - d0, 1);
    chk("small_running_after", int'(s_running), 0);
    chk("small_cycles", s_done_cyc - s_first_cyc + 1, 9);
    chk("small_outputs", s_outs - o0, 4);
    chk("small_fires", s_fires - f0, 4);
    chk("small_zero_flags", s_zero, 0);
    chk("small_first_last", s_bad, 0);
    $display("run k1_small: outputs %0d cycles %0d", s_outs - o0, s_done_cyc - s_first_cyc + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_loop_scheduler.md
# conv_loop_scheduler

Loop sequencer for the convolution datapath inside `top_system`. It walks every output pixel and output channel of a zero-padded "same" convolution, paces the MAC unit through the K×K×Cin taps with valid/ready handshakes on the activation (`a`) and weight (`b`) streams, and generates the padding zero flags. It also drives accumulate/first/last strobes and emits one `output_valid` per finished output with its coordinates.

## Interface
- FEATURE_MAP_WIDTH, 128, output/input width W
- FEATURE_MAP_HEIGHT, 128, output/input height H
- INPUT_NB_CHANNELS, 2, Cin
- OUTPUT_NB_CHANNELS, 16, Cout
- KERNEL_SIZE, 3, K (odd, ≥1)
- Clocking: one clock; reset is synchronous and active-low.

Ports:
- clk  in  1  clock
- arst_n_in  in  1  active-low reset, sampled on rising clk (synchronous)
- start  in  1  begin one full layer; honoured only in IDLE
- running  out  1  high in every state except IDLE
- fsm_done  out  1  one-cycle pulse in DONE
- a_valid  in  1  activation word available
- a_ready  out  1  activation consumed this cycle
- b_valid  in  1  weight word available
- b_ready  out  1  weight consumed this cycle
- a_zero_flag  out  1  current tap lies in padding; `a` treated as 0, not fetched
- tap_x, tap_y  out  $clog2(W)+1 / $clog2(H)+1 (signed)  input coordinate of current tap
- tap_ci  out  $clog2(Cin)  current input channel
- mac_valid  out  1  MAC fires this cycle
- mac_first  out  1  with mac_valid: load product, do not accumulate
- mac_last  out  1  with mac_valid: final tap of this output
- output_valid  out  1  accumulator holds finished result
- output_x, output_y, output_ch  out  $clog2(W), $clog2(H), $clog2(Cout)  coordinates of that result

## Operation
- States: IDLE, MAC, OUT, DONE.
- Loop order, outermost first: y, x, co, ky, kx, ci. All counters are 0 in IDLE.
- Tap coordinates: tap_x = x + kx − (K−1)/2 and tap_y = y + ky − (K−1)/2, both signed.
- pad = tap_x<0 | tap_x≥W | tap_y<0 | tap_y≥H; a_zero_flag = pad in MAC, else 0.
- fire = state==MAC & (a_valid|pad) & b_valid.
- a_ready = state==MAC & !pad & b_valid.
- b_ready = state==MAC & (a_valid|pad).
- Ready is combinational from valid; sources must not make valid depend on ready.
- mac_valid = fire.
- mac_first = fire & ky==0 & kx==0 & ci==0.
- mac_last = fire & ky==K−1 & kx==K−1 & ci==Cin−1.
- On fire, advance ci→kx→ky with carries. On mac_last, go to OUT.
- OUT lasts exactly one cycle with output_valid=1 and output_x/y/ch = x/y/co.
- Leaving OUT, advance co→x→y. If y, x and co are all at their maxima, go to DONE; else go to MAC.
- DONE lasts one cycle with fsm_done=1, then IDLE.
- IDLE→MAC on start. A start seen outside IDLE is ignored.
- There is no output backpressure. The downstream consumer must accept output_valid unconditionally.

## Timing
- Reset (arst_n_in=0 at a rising edge) forces IDLE and clears all counters. Every output is 0 the following cycle, including running, fsm_done, output_valid, all ready and strobe signals, and all coordinates.
- Reset mid-layer aborts with no output_valid or fsm_done pulse.
- start sampled at edge t puts the block in MAC at t+1; running=1 from t+1.
- With both streams always valid, each output takes K·K·Cin MAC cycles + 1 OUT cycle.
- Layer time = W·H·Cout·(K²·Cin+1) + 1 (DONE) cycles from the first MAC cycle.
- A stall is any cycle with no fire. During a stall all counters and outputs hold, and ready signals follow the rule above.
- Padded taps need only b_valid and never raise a_ready.
- output_x/y/ch are registered and hold their last value outside OUT.
- fsm_done and running: running drops the cycle after DONE.

## Test plan
1. W=H=4, Cin=2, Cout=2, K=3, a_valid=b_valid=1 constant, start pulse. Expect:
   - fsm_done exactly 32·19+1 = 609 cycles after first MAC cycle.
   - 32 output_valid pulses in order (y,x,co) = (0,0,0),(0,0,1),(0,1,0)…(3,3,1).
   - mac_first count 32, mac_last count 32.
2. Same config, corner output (0,0). Expect:
   - a_zero_flag=1 on exactly 10 of its 18 taps: ky=0 or kx=0 (5 positions ×2 ch).
   - a_ready=0 on those taps; total a_ready pulses for output (0,0,co) = 8.
3. Random independent a_valid/b_valid at 50% duty. Expect:
   - Output ordering and counts identical to test 1.
   - No fire without both handshakes satisfied.
   - Counters frozen on every stall cycle.
4. Assert arst_n_in=0 for 1 cycle mid-layer (after 100 fires). Expect:
   - All outputs 0 the next cycle.
   - No fsm_done pulse.
   - A new start then yields a full 609-cycle run from (0,0,0).
5. Pulse start again while running. Expect no effect; output count remains 32.
6. K=1, W=H=2, Cin=1, Cout=1. Expect:
   - a_zero_flag never set.
   - Every fire has mac_first=mac_last=1.
   - 4 outputs, fsm_done 9 cycles after first MAC.
